hsv_core_commit: RTL and testbench
==================================

# hsv_core_commit

Commit stage of the hsv_core pipeline, sitting at the consumer end of the execute→commit interface. It accepts one `commit_data_t` (pc, result) per cycle from the execute stage through a valid/ready handshake and buffers it in a 2-entry queue. It then retires instructions in order: it writes the result to the register file, reports the retired pc, and maintains the retired-instruction counter. It also honours pipeline flush and downstream stall.

## Interface
- `INSTRET_WIDTH`, default 64: width of the retired-instruction counter.
- `clk_core`, in, 1: core clock; all state updates on its rising edge.
- `rst_core`, in, 1: reset, synchronous, active-high.
- `flush`, in, 1: discard all buffered, unretired entries.
- `stall`, in, 1: hold the head entry; retire nothing this cycle.
- `in_valid`, in, 1: execute stage presents an entry.
- `in_ready`, out, 1: commit stage can accept an entry.
- `in_data`, in, 64: `commit_data_t` (pc, result).
- `in_rd`, in, 5: destination register.
- `in_rd_write`, in, 1: the instruction writes `rd`.
- `rf_wr_en`, out, 1: register-file write strobe.
- `rf_wr_addr`, out, 5: register-file write address.
- `rf_wr_data`, out, 32: register-file write data.
- `retire_valid`, out, 1: one instruction retired (one-cycle pulse per instruction).
- `retire_pc`, out, 32: pc of the retired instruction.
- `instret`, out, INSTRET_WIDTH: count of retired instructions.

## Operation
- **Accept:** an entry is accepted on an edge where `in_valid && in_ready`.
  - `in_ready = (count != 2) && !flush && !rst_core`.
  - `count` is the registered occupancy (0..2).
- **Retire:** the head entry retires on an edge where `count != 0 && !stall && !flush`. On that edge:
  - `retire_valid` ← 1 and `retire_pc` ← head pc.
  - `instret` ← `instret` + 1. It wraps modulo 2^INSTRET_WIDTH with no saturation.
  - `rf_wr_en` ← `head.rd_write && head.rd != 0`, so x0 is never written. `rf_wr_addr` ← head rd and `rf_wr_data` ← head result.
- **Non-retire edges:** `retire_valid` and `rf_wr_en` ← 0. `retire_pc`, `rf_wr_addr` and `rf_wr_data` hold their last values.
- **Simultaneous accept and retire:** allowed when `count == 1`; `count` stays 1 and order is preserved. At `count == 2`, `in_ready` is 0 even if a retire happens that edge, so there is no bypass.
- **Flush:**
  - `count` ← 0; the buffered entries neither retire nor write.
  - `instret` is unchanged; `retire_valid` and `rf_wr_en` ← 0 on the next cycle.
  - `in_ready` is low during the flush cycle, so `in_valid` is ignored.
  - Flush takes priority over stall and retire.
- **Stall with empty queue:** no effect except that the outputs stay idle.
- **Reset:** `count` ← 0, `instret` ← 0, and all outputs ← 0. `in_ready` is 0 while `rst_core` is high. Reset mid-stream drops all entries without retiring them.

## Timing
- Latency: an entry accepted at edge N retires at edge N+1 (queue empty, no stall). `rf_wr_*` and `retire_*` are valid in the cycle after edge N+1.
- Throughput: 1 instruction/cycle sustained with `stall` low.
- All outputs are registered. `in_ready` is a function of registered `count` plus the `flush` and `rst_core` inputs only; it has no dependency on `in_valid`.
- Stall of k cycles with `count == 2`: `in_ready` stays 0 for k cycles. The queue resumes at 1/cycle after `stall` drops.

## Structure
- Shared `hsv_core_pkg` holds:
  - the existing `commit_data_t` and `word`;
  - new `typedef logic [4:0] reg_addr`;
  - new `commit_entry_t` struct {`commit_data_t data`; `reg_addr rd`; `logic rd_write`}.
- Sub-module `hsv_core_commit_fifo`: a 2-entry in-order queue of `commit_entry_t`. It has push/pop/flush controls and `count`/head outputs, with synchronous active-high reset.
- The top level `hsv_core_commit` contains the retire logic, output registers and `instret` counter.

## Test plan
- **Single instruction:** push pc=0x100, result=0xDEADBEEF, rd=5, rd_write=1.
  - Expect `rf_wr_en`=1, addr=5, data=0xDEADBEEF, `retire_pc`=0x100 two cycles after acceptance.
  - Expect `instret`=1.
- **x0 / no-write:** push rd=0 with rd_write=1, then rd=7 with rd_write=0.
  - Expect both to retire (`retire_valid` pulses twice, `instret`=2).
  - Expect `rf_wr_en` never asserted.
- **Back-pressure:** hold `stall`=1 and push 3 entries.
  - Expect 2 accepted, then `in_ready`=0.
  - Release `stall`: the 3rd entry is accepted. Expect retires in order with pcs 0x0, 0x4, 0x8 on consecutive cycles.
- **Flush:** with 2 entries buffered and `stall`=1, assert `flush` for one cycle.
  - Expect no retire, `instret` unchanged, and `count`=0.
  - The next pushed pc=0x200 retires normally.
- **Streaming:** push 100 back-to-back entries with `stall`=0.
  - Expect `in_ready` constantly 1, 100 in-order retires on consecutive cycles, and `instret`=100.
- **Wrap and reset:** with INSTRET_WIDTH=4, retire 17 instructions and expect `instret`=1.
  - Assert `rst_core` mid-stream: expect all outputs 0 and `in_ready`=0 during reset, and no buffered entry retiring afterwards.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared hsv_core types: execute->commit payload, register addresses and
// the commit queue entry.
package hsv_core_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    word pc;
    word result;
  } commit_data_t;

  typedef logic [4:0] reg_addr;

  typedef struct packed {
    commit_data_t data;
    reg_addr      rd;
    logic         rd_write;
  } commit_entry_t;

  localparam int unsigned COMMIT_DEPTH = 2;
  localparam logic [1:0]  COMMIT_FULL  = 2'd2;
  localparam reg_addr     REG_ZERO     = 5'd0;

  // x0 is hardwired to zero, so a write to it is never issued.
  function automatic logic writes_rf(input commit_entry_t entry);
    return entry.rd_write && (entry.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/hsv_core_commit_fifo.sv
// Two-entry in-order queue of commit entries with push/pop/flush controls.
module hsv_core_commit_fifo
  import hsv_core_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  commit_entry_t push_entry,
  input  logic          pop,
  output logic [1:0]    count,
  output commit_entry_t head
);

  commit_entry_t mem_r [COMMIT_DEPTH];
  logic          rd_ptr_r;
  logic          wr_ptr_r;
  logic [1:0]    count_r;

  // Entry storage; occupancy tracking makes stale slots harmless, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head and occupancy are straight views of the registered state.
  always_comb begin
    count = count_r;
    head  = mem_r[rd_ptr_r];
  end

endmodule

// File: rtl/hsv_core_commit.sv
// Commit stage: buffers execute results and retires them in order, driving
// the register-file write port, retired pc and the instret counter.
module hsv_core_commit
  import hsv_core_pkg::*;
#(
  parameter int unsigned INSTRET_WIDTH = 64
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  commit_data_t             in_data,
  input  logic [4:0]               in_rd,
  input  logic                     in_rd_write,
  output logic                     rf_wr_en,
  output logic [4:0]               rf_wr_addr,
  output logic [31:0]              rf_wr_data,
  output logic                     retire_valid,
  output logic [31:0]              retire_pc,
  output logic [INSTRET_WIDTH-1:0] instret
);

  logic [1:0]    count_s;
  commit_entry_t head_s;
  commit_entry_t push_entry_s;
  logic          push_s;
  logic          pop_s;

  // Handshake and retire decisions; no bypass at full, flush beats everything.
  always_comb begin
    in_ready              = (count_s != COMMIT_FULL) && !flush && !rst_core;
    push_s                = in_valid && in_ready;
    pop_s                 = (count_s != 2'd0) && !stall && !flush;
    push_entry_s.data     = in_data;
    push_entry_s.rd       = in_rd;
    push_entry_s.rd_write = in_rd_write;
  end

  hsv_core_commit_fifo u_fifo (
    .clk        (clk_core),
    .rst        (rst_core),
    .flush      (flush),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .count      (count_s),
    .head       (head_s)
  );

  // Retire output registers; address, data and pc hold between retires.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      retire_valid <= 1'b0;
      retire_pc    <= 32'd0;
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= 5'd0;
      rf_wr_data   <= 32'd0;
      instret      <= '0;
    end else if (pop_s) begin
      retire_valid <= 1'b1;
      retire_pc    <= head_s.data.pc;
      rf_wr_en     <= writes_rf(head_s);
      rf_wr_addr   <= head_s.rd;
      rf_wr_data   <= head_s.data.result;
      instret      <= instret + INSTRET_WIDTH'(1'b1);
    end else begin
      retire_valid <= 1'b0;
      rf_wr_en     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hsv_core_commit.sv
// Self-checking bench for hsv_core_commit: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_hsv_core_commit;
  import hsv_core_pkg::*;

  logic         clk_core = 1'b0;
  logic         rst_core;
  logic         flush;
  logic         stall;
  logic         in_valid;
  commit_data_t in_data;
  logic [4:0]   in_rd;
  logic         in_rd_write;

  logic         in_ready, rf_wr_en, retire_valid;
  logic [4:0]   rf_wr_addr;
  logic [31:0]  rf_wr_data, retire_pc;
  logic [63:0]  instret;

  logic         in_ready_w4, rf_wr_en_w4, retire_valid_w4;
  logic [4:0]   rf_wr_addr_w4;
  logic [31:0]  rf_wr_data_w4, retire_pc_w4;
  logic [3:0]   instret_w4;

  int n_checks = 0;
  int n_fail = 0;
  int retire_seen = 0;
  bit started = 1'b0;

  commit_entry_t model_q [$];
  logic          exp_rv = 1'b0;
  logic          exp_we = 1'b0;
  logic [31:0]   exp_pc = 32'd0;
  logic [4:0]    exp_addr = 5'd0;
  logic [31:0]   exp_data = 32'd0;
  logic [63:0]   exp_instret = 64'd0;

  always #5 clk_core = ~clk_core;

  hsv_core_commit dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .in_rd_write(in_rd_write), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .instret(instret)
  );

  hsv_core_commit #(.INSTRET_WIDTH(4)) dut_w4 (
    .clk_core(clk_core), .rst_core(rst_core), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready_w4), .in_data(in_data), .in_rd(in_rd),
    .in_rd_write(in_rd_write), .rf_wr_en(rf_wr_en_w4), .rf_wr_addr(rf_wr_addr_w4),
    .rf_wr_data(rf_wr_data_w4), .retire_valid(retire_valid_w4), .retire_pc(retire_pc_w4),
    .instret(instret_w4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_core);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] res,
                        input logic [4:0] rd, input logic wr);
    in_valid       = v;
    in_data.pc     = pc;
    in_data.result = res;
    in_rd          = rd;
    in_rd_write    = wr;
  endtask

  // Compare DUT against the model, then advance the model with the inputs
  // that will be sampled at the coming rising edge.
  always begin
    commit_entry_t e;
    logic          accept;
    @(negedge clk_core);
    #2;
    if (retire_valid === 1'b1) retire_seen++;
    if (started) begin
      check("retire_valid", {63'd0, retire_valid}, {63'd0, exp_rv});
      check("retire_pc", {32'd0, retire_pc}, {32'd0, exp_pc});
      check("rf_wr_en", {63'd0, rf_wr_en}, {63'd0, exp_we});
      check("rf_wr_addr", {59'd0, rf_wr_addr}, {59'd0, exp_addr});
      check("rf_wr_data", {32'd0, rf_wr_data}, {32'd0, exp_data});
      check("instret", instret, exp_instret);
      check("in_ready", {63'd0, in_ready},
            {63'd0, (model_q.size() != 2) && !flush && !rst_core});
      check("w4_retire_valid", {63'd0, retire_valid_w4}, {63'd0, exp_rv});
      check("w4_retire_pc", {32'd0, retire_pc_w4}, {32'd0, exp_pc});
      check("w4_rf_wr_en", {63'd0, rf_wr_en_w4}, {63'd0, exp_we});
      check("w4_instret", {60'd0, instret_w4}, {60'd0, exp_instret[3:0]});
      check("w4_in_ready", {63'd0, in_ready_w4}, {63'd0, in_ready});
    end
    if (rst_core) begin
      model_q.delete();
      exp_rv = 1'b0; exp_we = 1'b0; exp_pc = 32'd0;
      exp_addr = 5'd0; exp_data = 32'd0; exp_instret = 64'd0;
    end else if (flush) begin
      model_q.delete();
      exp_rv = 1'b0; exp_we = 1'b0;
    end else begin
      accept = in_valid && (model_q.size() != 2);
      if (model_q.size() != 0 && !stall) begin
        e = model_q.pop_front();
        exp_rv = 1'b1;
        exp_pc = e.data.pc;
        exp_we = e.rd_write && (e.rd != 5'd0);
        exp_addr = e.rd;
        exp_data = e.data.result;
        exp_instret = exp_instret + 64'd1;
      end else begin
        exp_rv = 1'b0;
        exp_we = 1'b0;
      end
      if (accept) begin
        e.data = in_data;
        e.rd = in_rd;
        e.rd_write = in_rd_write;
        model_q.push_back(e);
      end
    end
  end

  initial begin
    int seen0;
    int pulses;
    int writes;
    rst_core = 1'b1; flush = 1'b0; stall = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); tick();
    started = 1'b1;
    #3;
    check("reset_retire_valid", {63'd0, retire_valid}, 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    tick(); rst_core = 1'b0;

    // Single instruction
    tick(); set_in(1'b1, 32'h100, 32'hDEADBEEF, 5'd5, 1'b1);
    tick(); set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); #3;
    check("single_rf_wr_en", {63'd0, rf_wr_en}, 64'd1);
    check("single_rf_wr_addr", {59'd0, rf_wr_addr}, 64'd5);
    check("single_rf_wr_data", {32'd0, rf_wr_data}, 64'hDEADBEEF);
    check("single_retire_pc", {32'd0, retire_pc}, 64'h100);
    check("single_instret", instret, 64'd1);

    // x0 write and no-write entries
    tick(); set_in(1'b1, 32'h110, 32'h11, 5'd0, 1'b1);
    tick(); set_in(1'b1, 32'h114, 32'h22, 5'd7, 1'b0);
    pulses = 0; writes = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      #3;
      if (retire_valid === 1'b1) pulses++;
      if (rf_wr_en !== 1'b0) writes++;
    end
    check("x0_retire_pulses", 64'(pulses), 64'd2);
    check("x0_rf_writes", 64'(writes), 64'd0);
    check("x0_instret", instret, 64'd3);

    // Back-pressure
    stall = 1'b1;
    tick(); set_in(1'b1, 32'h0, 32'hA0, 5'd1, 1'b1); #1;
    check("bp_ready0", {63'd0, in_ready}, 64'd1);
    tick(); set_in(1'b1, 32'h4, 32'hA4, 5'd2, 1'b1); #1;
    check("bp_ready1", {63'd0, in_ready}, 64'd1);
    tick(); set_in(1'b1, 32'h8, 32'hA8, 5'd3, 1'b1); #1;
    check("bp_full", {63'd0, in_ready}, 64'd0);
    tick(); #1;
    check("bp_full_held", {63'd0, in_ready}, 64'd0);
    tick(); stall = 1'b0; #1;
    check("bp_release_ready", {63'd0, in_ready}, 64'd0);
    tick(); #1;
    check("bp_third_ready", {63'd0, in_ready}, 64'd1);
    #2;
    check("bp_retire0", {31'd0, retire_valid, retire_pc}, {31'd0, 1'b1, 32'h0});
    tick(); set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0); #3;
    check("bp_retire1", {31'd0, retire_valid, retire_pc}, {31'd0, 1'b1, 32'h4});
    tick(); #3;
    check("bp_retire2", {31'd0, retire_valid, retire_pc}, {31'd0, 1'b1, 32'h8});
    tick(); #3;
    check("bp_idle", {63'd0, retire_valid}, 64'd0);

    // Flush
    stall = 1'b1;
    tick(); set_in(1'b1, 32'h300, 32'h30, 5'd8, 1'b1);
    tick(); set_in(1'b1, 32'h304, 32'h34, 5'd9, 1'b1);
    tick(); flush = 1'b1; set_in(1'b1, 32'h3FF, 32'h3F, 5'd10, 1'b1); #1;
    check("flush_ready_low", {63'd0, in_ready}, 64'd0);
    tick(); flush = 1'b0; stall = 1'b0; set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0); #3;
    check("flush_no_retire", {63'd0, retire_valid}, 64'd0);
    check("flush_instret", instret, 64'd6);
    check("flush_empty_ready", {63'd0, in_ready}, 64'd1);
    tick(); #3;
    check("flush_still_idle", {63'd0, retire_valid | rf_wr_en}, 64'd0);
    tick(); set_in(1'b1, 32'h200, 32'h20, 5'd11, 1'b1);
    tick(); set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); #3;
    check("flush_next_retire", {31'd0, retire_valid, retire_pc}, {31'd0, 1'b1, 32'h200});
    check("flush_next_instret", instret, 64'd7);

    // Streaming
    seen0 = retire_seen;
    for (int i = 0; i < 100; i++) begin
      tick(); set_in(1'b1, 32'h1000 + 32'(4 * i), 32'(i * 3), 5'(i % 32), 1'b1); #1;
      check("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    tick(); set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); #3;
    check("stream_retires", 64'(retire_seen - seen0), 64'd100);
    check("stream_instret", instret, 64'd107);
    check("stream_last_pc", {32'd0, retire_pc}, 64'h118C);

    // Reset mid-stream
    stall = 1'b1;
    tick(); set_in(1'b1, 32'h500, 32'h50, 5'd3, 1'b1);
    tick(); set_in(1'b1, 32'h504, 32'h54, 5'd4, 1'b1);
    tick(); rst_core = 1'b1; stall = 1'b0; set_in(1'b1, 32'h508, 32'h58, 5'd5, 1'b1); #1;
    check("rst_ready_low", {63'd0, in_ready}, 64'd0);
    tick(); #3;
    check("rst_outputs", {rf_wr_data, retire_pc}, 64'd0);
    check("rst_ctrl", {57'd0, retire_valid, rf_wr_en, rf_wr_addr}, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_instret_w4", {60'd0, instret_w4}, 64'd0);
    tick(); rst_core = 1'b0; set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0); #3;
    check("rst_no_retire", {63'd0, retire_valid}, 64'd0);
    tick(); #3;
    check("rst_no_retire2", {63'd0, retire_valid | rf_wr_en}, 64'd0);

    // Wrap of the narrow counter
    for (int i = 0; i < 17; i++) begin
      tick(); set_in(1'b1, 32'h2000 + 32'(4 * i), 32'(i), 5'd12, 1'b1);
    end
    tick(); set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); #3;
    check("wrap_instret_w4", {60'd0, instret_w4}, 64'd1);
    check("wrap_instret", instret, 64'd17);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
